// File: rtl/pc_fetch_ctrl.sv
// PC register, next-PC select and fetch FSM (boot / run / halt / fault) ahead of the instruction ROM.
// Optional retired-instruction counter built only when PC_PERF_CNT_EN is defined.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 100,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Instr,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] SignImm,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Valid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] Retired
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] candidate;
    logic        retire_en;

    // A fetch address is legal only when word aligned and inside the ROM.
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] == 2'b00) && (word_idx < 32'(IMEM_WORDS));
    endfunction

    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_target = pc_plus4 + {SignImm[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], Instr[25:0], 2'b00};
    assign candidate     = Jump ? jump_target : (PCSrc ? branch_target : pc_plus4);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        retire_en  = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = in_range(pc_reg) ? ST_RUN : ST_FAULT;
            end
            ST_RUN: begin
                if (!Stall) begin
                    if (Instr == HALT_INSTR) begin
                        state_next = ST_HALT;
                    end else if (!in_range(candidate)) begin
                        // PC keeps the last good address so the faulting fetch can be traced.
                        state_next = ST_FAULT;
                    end else begin
                        pc_next   = candidate;
                        retire_en = 1'b1;
                    end
                end
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_BOOT;
            pc_reg    <= RESET_VECTOR;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    assign PC      = pc_reg;
    assign PCPlus4 = pc_plus4;
    assign Valid   = (state_reg == ST_RUN);
    assign Halted  = (state_reg == ST_HALT);
    assign Fault   = (state_reg == ST_FAULT);

`ifdef PC_PERF_CNT_EN
    logic [31:0] retired_reg;

    // Saturating so a long run never wraps back to a small count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_reg <= 32'd0;
        end else if (retire_en && (retired_reg != 32'hFFFF_FFFF)) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign Retired = retired_reg;

    logic unused_bits;
    assign unused_bits = &{1'b0, SignImm[31:30]};
`else
    assign Retired = 32'd0;

    logic unused_bits;
    assign unused_bits = &{1'b0, SignImm[31:30], retire_en};
`endif

endmodule
